uart_rx_unwarp: RTL and testbench

Receive-side deframer for the coincidence upload link. It consumes the byte stream recovered by `uart_rx`, finds frames of the form header `0xFF`, then `INDATA_WIDTH/8` payload bytes, then ender `0xEE`, and rebuilds each payload into one parallel word with a single-cycle valid strobe. It sits behind `uart_rx` in loopback benches and companion boards, so the link can be checked end-to-end against what `uart_tx_warp` sends. It also keeps frame and error statistics.

---
 rtl/uart_rx_unwarp.sv | 105 ++++++++++
 tb/tb_uart_rx_unwarp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_unwarp.sv
// rtl/uart_rx_unwarp.sv - deframes FF/payload/EE byte frames into parallel words with stats
module uart_rx_unwarp #(
  parameter int          INDATA_WIDTH   = 88,
  parameter logic [7:0]  TX_HEADER      = 8'hFF,
  parameter logic [7:0]  TX_ENDER       = 8'hEE,
  parameter int          TIMEOUT_CYCLES = 65536,
  parameter int          CNT_WIDTH      = 16
) (
  input  logic                    clk_200M,
  input  logic                    rst_n_e,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  output logic [INDATA_WIDTH-1:0] frame_data,
  output logic                    frame_valid,
  output logic                    frame_error,
  output logic [CNT_WIDTH-1:0]    frame_cnt,
  output logic [CNT_WIDTH-1:0]    err_cnt
);

  localparam int NBYTES = INDATA_WIDTH / 8;
  localparam int BC_W   = $clog2(NBYTES + 1);
  localparam int TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_ENDER} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [BC_W-1:0]         bcnt;
  logic [TO_W-1:0]         tcnt;
  logic [INDATA_WIDTH-1:0] shreg;
  logic                    timeout;
  logic                    good_end;
  logic                    bad_end;

  // A byte on the expiry cycle wins over the timeout.
  assign timeout = (state != S_IDLE) && !byte_valid &&
                   (tcnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_200M or negedge rst_n_e) begin
    if (!rst_n_e) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (byte_valid && byte_in == TX_HEADER) state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (byte_valid && bcnt == BC_W'(NBYTES - 1)) state_nxt = S_ENDER;
        else if (timeout)                             state_nxt = S_IDLE;
      end
      S_ENDER: begin
        if (byte_valid || timeout) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    good_end = 1'b0;
    bad_end  = timeout;
    if (state == S_ENDER && byte_valid) begin
      good_end = (byte_in == TX_ENDER);
      bad_end  = (byte_in != TX_ENDER);
    end
  end

  always_ff @(posedge clk_200M or negedge rst_n_e) begin
    if (!rst_n_e) begin
      bcnt  <= '0;
      tcnt  <= '0;
      shreg <= '0;
    end else begin
      if (state == S_IDLE || byte_valid || timeout) tcnt <= '0;
      else                                          tcnt <= tcnt + 1'b1;
      if (state == S_IDLE && byte_valid && byte_in == TX_HEADER) begin
        bcnt <= '0;
      end else if (state == S_PAYLOAD && byte_valid) begin
        bcnt  <= bcnt + 1'b1;
        shreg <= (shreg << 8) | INDATA_WIDTH'(byte_in);
      end
    end
  end

  always_ff @(posedge clk_200M or negedge rst_n_e) begin
    if (!rst_n_e) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      frame_valid <= good_end;
      frame_error <= bad_end;
      if (good_end) begin
        frame_data <= shreg;
        if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
      end
      if (bad_end && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_unwarp.sv
// tb/tb_uart_rx_unwarp.sv - directed self-checking bench for uart_rx_unwarp
module tb_uart_rx_unwarp;

  logic        clk_200M;
  logic        rst_n_e;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [87:0] frame_data;
  logic        frame_valid;
  logic        frame_error;
  logic [3:0]  frame_cnt;
  logic [3:0]  err_cnt;

  int vectors;
  int miscompares;
  int fv_cnt;
  int fe_cnt;
  int fv0;
  int fe0;
  logic [87:0] p1;
  logic [87:0] p2;

  uart_rx_unwarp #(
    .INDATA_WIDTH  (88),
    .TX_HEADER     (8'hFF),
    .TX_ENDER      (8'hEE),
    .TIMEOUT_CYCLES(100),
    .CNT_WIDTH     (4)
  ) dut (
    .clk_200M   (clk_200M),
    .rst_n_e    (rst_n_e),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_error(frame_error),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  initial clk_200M = 1'b0;
  always #2 clk_200M = ~clk_200M;

  // Reads the pre-edge values, so each one-cycle pulse is counted once.
  always @(posedge clk_200M) begin
    if (frame_valid) fv_cnt++;
    if (frame_error) fe_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk_200M);
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic send_payload(input logic [87:0] p);
    for (int i = 0; i < 11; i++) send_byte(p[87-8*i -: 8]);
  endtask

  task automatic send_frame(input logic [87:0] p);
    send_byte(8'hFF);
    send_payload(p);
    send_byte(8'hEE);
  endtask

  task automatic do_reset();
    rst_n_e = 1'b0;
    repeat (2) @(negedge clk_200M);
    rst_n_e = 1'b1;
    @(negedge clk_200M);
  endtask

  initial begin
    vectors = 0; miscompares = 0; fv_cnt = 0; fe_cnt = 0;
    rst_n_e = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
    p1 = 88'h0102030405060708090A0B;
    p2 = 88'hEEFFEEFF000000000000_11;
    repeat (3) @(negedge clk_200M);
    check("rst_data",  frame_data, 88'h0);
    check("rst_valid", frame_valid, 1'b0);
    check("rst_error", frame_error, 1'b0);
    check("rst_fcnt",  frame_cnt, 4'h0);
    check("rst_ecnt",  err_cnt, 4'h0);
    rst_n_e = 1'b1;
    @(negedge clk_200M);

    send_frame(p1);
    check("good_valid", frame_valid, 1'b1);
    check("good_data",  frame_data, 88'h0102030405060708090A0B);
    check("good_fcnt",  frame_cnt, 4'h1);
    check("good_ecnt",  err_cnt, 4'h0);
    check("good_error", frame_error, 1'b0);
    @(negedge clk_200M);
    check("good_valid_drop", frame_valid, 1'b0);
    check("good_data_hold",  frame_data, 88'h0102030405060708090A0B);
    repeat (2) @(negedge clk_200M);
    check("good_pulses", fv_cnt, 1);

    send_frame(p2);
    check("ffee_valid", frame_valid, 1'b1);
    check("ffee_data",  frame_data, 88'hEEFFEEFF00000000000011);
    check("ffee_fcnt",  frame_cnt, 4'h2);
    repeat (3) @(negedge clk_200M);
    check("ffee_pulses", fv_cnt, 2);

    do_reset();
    fv0 = fv_cnt; fe0 = fe_cnt;
    send_byte(8'hFF);
    send_payload(p1);
    send_byte(8'hFF);
    check("bad_error", frame_error, 1'b1);
    check("bad_ecnt",  err_cnt, 4'h1);
    check("bad_data",  frame_data, 88'h0);
    send_payload(p1);
    send_byte(8'hEE);
    check("bad_no_resync_valid", frame_valid, 1'b0);
    check("bad_no_resync_fcnt",  frame_cnt, 4'h0);
    send_frame(p1);
    check("bad_next_valid", frame_valid, 1'b1);
    check("bad_next_fcnt",  frame_cnt, 4'h1);
    repeat (2) @(negedge clk_200M);
    check("bad_err_pulses", fe_cnt - fe0, 1);
    check("bad_val_pulses", fv_cnt - fv0, 1);

    fe0 = fe_cnt;
    send_byte(8'hFF);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    repeat (99) @(negedge clk_200M);
    check("to_not_yet", frame_error, 1'b0);
    @(negedge clk_200M);
    check("to_fire", frame_error, 1'b1);
    check("to_ecnt", err_cnt, 4'h2);
    @(negedge clk_200M);
    check("to_drop", frame_error, 1'b0);
    send_frame(p2);
    check("to_next_valid", frame_valid, 1'b1);
    check("to_next_data",  frame_data, 88'hEEFFEEFF00000000000011);
    check("to_next_fcnt",  frame_cnt, 4'h2);

    fe0 = fe_cnt;
    send_byte(8'hFF);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    repeat (99) @(negedge clk_200M);
    send_byte(8'h06);
    check("edge_no_error", frame_error, 1'b0);
    for (int i = 7; i <= 11; i++) send_byte(8'(i));
    send_byte(8'hEE);
    check("edge_valid", frame_valid, 1'b1);
    check("edge_data",  frame_data, 88'h0102030405060708090A0B);
    check("edge_fcnt",  frame_cnt, 4'h3);
    check("edge_ecnt",  err_cnt, 4'h2);
    repeat (2) @(negedge clk_200M);
    check("edge_err_pulses", fe_cnt - fe0, 0);

    fe0 = fe_cnt;
    send_byte(8'hFF);
    for (int i = 1; i <= 5; i++) send_byte(8'h50 + 8'(i));
    rst_n_e = 1'b0;
    #1;
    check("mrst_data",  frame_data, 88'h0);
    check("mrst_fcnt",  frame_cnt, 4'h0);
    check("mrst_ecnt",  err_cnt, 4'h0);
    check("mrst_valid", frame_valid, 1'b0);
    check("mrst_error", frame_error, 1'b0);
    @(negedge clk_200M);
    rst_n_e = 1'b1;
    repeat (2) @(negedge clk_200M);
    check("mrst_no_err", fe_cnt - fe0, 0);
    send_frame(p2);
    check("mrst_next_valid", frame_valid, 1'b1);
    check("mrst_next_data",  frame_data, 88'hEEFFEEFF00000000000011);
    check("mrst_next_fcnt",  frame_cnt, 4'h1);

    do_reset();
    for (int i = 0; i < 15; i++) send_frame(p1);
    check("sat_15", frame_cnt, 4'hF);
    send_frame(p2);
    send_frame(p1);
    check("sat_17", frame_cnt, 4'hF);
    check("sat_valid", frame_valid, 1'b1);
    check("sat_data", frame_data, 88'h0102030405060708090A0B);
    check("sat_ecnt", err_cnt, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
